// File: rtl/fitbit_pkg.sv
// Shared definitions for the pedometer front end: conditioner FSM encoding,
// default cycle constants and the width of the saturating event counters.
package fitbit_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    RISE_QUAL = 2'd1,
    HIGH      = 2'd2,
    FALL_QUAL = 2'd3
  } cond_state_t;

  localparam int DEF_DEBOUNCE_CYCLES     = 1000;
  localparam int DEF_MIN_INTERVAL_CYCLES = 25_000_000;
  localparam int DEF_CNT_W               = 25;
  localparam int SAT_W                   = 8;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s_p0;

  // Stage p0 may go metastable; q is the settled copy one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p0 <= 1'b0;
      q    <= 1'b0;
    end else begin
      s_p0 <= d;
      q    <= s_p0;
    end
  end

endmodule

// File: rtl/step_pulse_conditioner.sv
// Turns the raw, bouncy step-sensor line into one single-cycle stepPulse per
// physical step, rejecting short glitches and implausibly fast cadence.
module step_pulse_conditioner
  import fitbit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_INTERVAL_CYCLES = DEF_MIN_INTERVAL_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic             clk100Mhz,
  input  logic             rst_n,
  input  logic             pulseRaw,
  output logic             stepPulse,
  output logic [SAT_W-1:0] glitchCount,
  output logic [SAT_W-1:0] tooFastCount,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_GAP  = CNT_W'(MIN_INTERVAL_CYCLES);

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
    return (v == {SAT_W{1'b1}}) ? v : v + SAT_W'(1);
  endfunction

  logic             sync_in;
  cond_state_t      state;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] interval_cnt;

  sync2 u_sync2 (
    .clk   (clk100Mhz),
    .rst_n (rst_n),
    .d     (pulseRaw),
    .q     (sync_in)
  );

  assign busy = (state != IDLE_LOW);

  // Qualification edge is the last of DEBOUNCE_CYCLES consecutive high samples
  always_ff @(posedge clk100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE_LOW;
      db_cnt       <= '0;
      interval_cnt <= MIN_GAP;
      stepPulse    <= 1'b0;
      glitchCount  <= '0;
      tooFastCount <= '0;
    end else begin
      stepPulse <= 1'b0;
      if (interval_cnt < MIN_GAP)
        interval_cnt <= interval_cnt + CNT_ONE;

      case (state)
        IDLE_LOW: begin
          if (sync_in) begin
            db_cnt <= CNT_ONE;
            state  <= RISE_QUAL;
          end
        end
        RISE_QUAL: begin
          if (!sync_in) begin
            glitchCount <= sat_inc(glitchCount);
            state       <= IDLE_LOW;
          end else if (db_cnt == DB_LAST) begin
            state <= HIGH;
            if (interval_cnt >= MIN_GAP) begin
              stepPulse    <= 1'b1;
              interval_cnt <= '0;
            end else begin
              tooFastCount <= sat_inc(tooFastCount);
            end
          end else begin
            db_cnt <= db_cnt + CNT_ONE;
          end
        end
        HIGH: begin
          if (!sync_in) begin
            db_cnt <= CNT_ONE;
            state  <= FALL_QUAL;
          end
        end
        FALL_QUAL: begin
          // A high sample here is contact bounce: resume HIGH without a new step
          if (sync_in)
            state <= HIGH;
          else if (db_cnt == DB_LAST)
            state <= IDLE_LOW;
          else
            db_cnt <= db_cnt + CNT_ONE;
        end
        default: state <= IDLE_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_conditioner.sv
// Directed bench for step_pulse_conditioner with DEBOUNCE_CYCLES=4, MIN_INTERVAL_CYCLES=20.
module tb_step_pulse_conditioner;
  import fitbit_pkg::*;

  localparam int DB  = 4;
  localparam int MIN = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pulseRaw = 1'b0;
  logic             stepPulse;
  logic [SAT_W-1:0] glitchCount;
  logic [SAT_W-1:0] tooFastCount;
  logic             busy;

  step_pulse_conditioner #(
    .DEBOUNCE_CYCLES     (DB),
    .MIN_INTERVAL_CYCLES (MIN),
    .CNT_W               (8)
  ) dut (
    .clk100Mhz    (clk),
    .rst_n        (rst_n),
    .pulseRaw     (pulseRaw),
    .stepPulse    (stepPulse),
    .glitchCount  (glitchCount),
    .tooFastCount (tooFastCount),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    seg[6];
    int    exp_pulses;
    int    exp_first;
    int    exp_last;
    int    exp_glitch;
    int    exp_fast;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;
  int   edge_no, pulses, first_edge, last_edge, consec;
  logic prev_pulse;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input string n, input int h1, l1, h2, l2, h3, l3,
                     input int np, fe, le, g, f);
    vec_t v;
    v.name = n;
    v.seg[0] = h1; v.seg[1] = l1; v.seg[2] = h2;
    v.seg[3] = l2; v.seg[4] = h3; v.seg[5] = l3;
    v.exp_pulses = np; v.exp_first = fe; v.exp_last = le;
    v.exp_glitch = g;  v.exp_fast = f;
    vecs.push_back(v);
  endtask

  task automatic clear_stats();
    edge_no = 0; pulses = 0; first_edge = -1; last_edge = -1;
    consec = 0; prev_pulse = 1'b0;
  endtask

  // Drive one level before edge N, sample #1 after edge N, return at the next negedge
  task automatic tick(input logic lvl);
    pulseRaw = lvl;
    @(posedge clk);
    #1;
    if (stepPulse === 1'b1) begin
      pulses++;
      if (first_edge < 0) first_edge = edge_no;
      last_edge = edge_no;
      if (prev_pulse) consec++;
    end
    prev_pulse = stepPulse;
    edge_no++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    pulseRaw = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    add("clean",       10, 10, 0,  0, 0,  0, 1, 5, 5,  0, 0);
    add("glitch",       3, 10, 0,  0, 0,  0, 0, -1, -1, 1, 0);
    add("minhigh",      4, 10, 0,  0, 0,  0, 1, 5, 5,  0, 0);
    add("bounce",       6,  2, 6, 10, 0,  0, 1, 5, 5,  0, 0);
    add("twoglitch",    3,  8, 3, 10, 0,  0, 0, -1, -1, 2, 0);
    add("refire_fast",  6,  5, 6, 10, 0,  0, 1, 5, 5,  0, 1);
    add("cadence",      6,  6, 6, 27, 6, 10, 2, 5, 50, 0, 1);

    // Reset state
    pulseRaw = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_step", stepPulse, 0);
    chk("rst_glitch", glitchCount, 0);
    chk("rst_fast", tooFastCount, 0);
    chk("rst_busy", busy, 0);

    foreach (vecs[i]) begin
      do_reset();
      for (int s = 0; s < 6; s++)
        for (int c = 0; c < vecs[i].seg[s]; c++)
          tick((s % 2) == 0);
      chk({vecs[i].name, "_pulses"}, pulses, vecs[i].exp_pulses);
      chk({vecs[i].name, "_first"}, first_edge, vecs[i].exp_first);
      chk({vecs[i].name, "_last"}, last_edge, vecs[i].exp_last);
      chk({vecs[i].name, "_glitch"}, glitchCount, vecs[i].exp_glitch);
      chk({vecs[i].name, "_fast"}, tooFastCount, vecs[i].exp_fast);
      chk({vecs[i].name, "_busy"}, busy, 0);
    end

    // Glitch counter saturation
    do_reset();
    for (int g = 1; g <= 300; g++) begin
      repeat (3) tick(1'b1);
      repeat (8) tick(1'b0);
      if (g == 100) chk("sat_g100", glitchCount, 100);
      if (g == 255) chk("sat_g255", glitchCount, 255);
      if (g == 260) chk("sat_g260", glitchCount, 255);
    end
    chk("sat_final", glitchCount, 255);
    chk("sat_pulses", pulses, 0);
    chk("sat_fast", tooFastCount, 0);

    // Reset mid-qualification, then hold the line high
    do_reset();
    repeat (5) tick(1'b1);
    chk("midq_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midq_rst_busy", busy, 0);
    chk("midq_rst_step", stepPulse, 0);
    repeat (5) tick(1'b1);
    chk("midq_rst_pulses", pulses, 0);
    chk("midq_rst_busy2", busy, 0);
    rst_n = 1'b1;
    clear_stats();
    repeat (1000) tick(1'b1);
    chk("hold_pulses", pulses, 1);
    chk("hold_first", first_edge, 5);
    chk("hold_consec", consec, 0);
    chk("hold_busy", busy, 1);
    chk("hold_glitch", glitchCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
